mips_bus_arbiter: RTL and testbench

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

---
 rtl/mips_bus_arbiter_if.sv | 64 ++++++
 rtl/mips_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_arbiter_if.sv
// mips_bus_arbiter_if: groups the per-port request side and the Avalon
// master side of the bus arbiter into one bundle.
// master modport: the arbiter's view. slave modport: requesters plus memory.
interface mips_bus_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int DATA_W  = 32
);
    localparam int BE_W = DATA_W / 8;

    // Per-port request side
    logic [N_PORTS*32-1:0]     port_address;
    logic [N_PORTS-1:0]        port_read;
    logic [N_PORTS-1:0]        port_write;
    logic [N_PORTS*DATA_W-1:0] port_writedata;
    logic [N_PORTS*BE_W-1:0]   port_byteenable;
    logic [DATA_W-1:0]         port_readdata;
    logic [N_PORTS-1:0]        port_done;
    logic                      busy;

    // Avalon master side
    logic [31:0]               address;
    logic                      write;
    logic                      read;
    logic [DATA_W-1:0]         writedata;
    logic [BE_W-1:0]           byteenable;
    logic                      waitrequest;
    logic [DATA_W-1:0]         readdata;

    modport master (
        input  port_address,
        input  port_read,
        input  port_write,
        input  port_writedata,
        input  port_byteenable,
        output port_readdata,
        output port_done,
        output busy,
        output address,
        output write,
        output read,
        output writedata,
        output byteenable,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        output port_address,
        output port_read,
        output port_write,
        output port_writedata,
        output port_byteenable,
        input  port_readdata,
        input  port_done,
        input  busy,
        input  address,
        input  write,
        input  read,
        input  writedata,
        input  byteenable,
        output waitrequest,
        input  readdata
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares one Avalon master among N_PORTS requesters.
// One transfer at a time: IDLE (arbitrate) -> BUS (hold request until
// waitrequest drops) -> DONE (one-cycle port_done pulse) -> IDLE.
// Optional feature: define MIPS_ARB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise the lowest-index requester always wins.
module mips_bus_arbiter #(
    parameter int N_PORTS = 2,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    mips_bus_arbiter_if.master bus
);
    localparam int BE_W = DATA_W / 8;
    localparam int GW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg,      state_next;
    logic [GW-1:0]       grant_reg,      grant_next;
    logic [31:0]         address_reg,    address_next;
    logic [DATA_W-1:0]   writedata_reg,  writedata_next;
    logic [BE_W-1:0]     byteenable_reg, byteenable_next;
    logic                read_reg,       read_next;
    logic                write_reg,      write_next;
    logic [DATA_W-1:0]   readdata_reg,   readdata_next;

    // Flattened request buses split into per-port views
    logic [N_PORTS-1:0]  req_vec;
    logic [31:0]         addr_arr  [N_PORTS];
    logic [DATA_W-1:0]   wdata_arr [N_PORTS];
    logic [BE_W-1:0]     be_arr    [N_PORTS];
    logic [GW-1:0]       winner;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign req_vec[gi]   = bus.port_read[gi] | bus.port_write[gi];
            assign addr_arr[gi]  = bus.port_address[32*gi +: 32];
            assign wdata_arr[gi] = bus.port_writedata[DATA_W*gi +: DATA_W];
            assign be_arr[gi]    = bus.port_byteenable[BE_W*gi +: BE_W];
            // Completion pulse is a pure decode of registered state, so it
            // clears the moment reset asserts.
            assign bus.port_done[gi] = (state_reg == DONE) && (grant_reg == GW'(gi));
        end
    endgenerate

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    logic [GW-1:0] last_grant_reg;
    logic          rr_found;

    // Winner is the first requester searching upward from the slot after
    // the previous winner, wrapping around.
    always_comb begin
        winner   = last_grant_reg;
        rr_found = 1'b0;
        for (int k = 1; k <= N_PORTS; k++) begin
            if (!rr_found && req_vec[(int'(last_grant_reg) + k) % N_PORTS]) begin
                winner   = GW'((int'(last_grant_reg) + k) % N_PORTS);
                rr_found = 1'b1;
            end
        end
    end

    // Pointer advances only when a granted transfer actually completes;
    // an aborted transfer leaves fairness untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= GW'(N_PORTS - 1);
        end else if (state_reg == DONE) begin
            last_grant_reg <= grant_reg;
        end
    end
`else
    // Fixed priority: lowest-index requester wins.
    always_comb begin
        winner = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (req_vec[k]) begin
                winner = GW'(k);
            end
        end
    end
`endif

    // Next-state and registered-output logic for the transfer sequencer.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        address_next    = address_reg;
        writedata_next  = writedata_reg;
        byteenable_next = byteenable_reg;
        read_next       = read_reg;
        write_next      = write_reg;
        readdata_next   = readdata_reg;

        unique case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    grant_next      = winner;
                    address_next    = addr_arr[winner];
                    writedata_next  = wdata_arr[winner];
                    byteenable_next = be_arr[winner];
                    // A port asserting both strobes is treated as a write.
                    write_next      = bus.port_write[winner];
                    read_next       = bus.port_read[winner] & ~bus.port_write[winner];
                    state_next      = BUS;
                end
            end
            BUS: begin
                if (!bus.waitrequest) begin
                    if (read_reg) begin
                        readdata_next = bus.readdata;
                    end
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            address_reg    <= '0;
            writedata_reg  <= '0;
            byteenable_reg <= '0;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
            readdata_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            address_reg    <= address_next;
            writedata_reg  <= writedata_next;
            byteenable_reg <= byteenable_next;
            read_reg       <= read_next;
            write_reg      <= write_next;
            readdata_reg   <= readdata_next;
        end
    end

    assign bus.address       = address_reg;
    assign bus.writedata     = writedata_reg;
    assign bus.byteenable    = byteenable_reg;
    assign bus.read          = read_reg;
    assign bus.write         = write_reg;
    assign bus.port_readdata = readdata_reg;
    assign bus.busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: directed stimulus with a transaction-level model of
// the 2-port arbiter checked every cycle, plus literal expectations for the
// individual scenarios and a 4-port / 64-bit instance.
module tb_mips_bus_arbiter;
    localparam int NP  = 2;
    localparam int DW  = 32;
    localparam int NP4 = 4;
    localparam int DW4 = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    mips_bus_arbiter_if #(.N_PORTS(NP),  .DATA_W(DW))  bus2 ();
    mips_bus_arbiter_if #(.N_PORTS(NP4), .DATA_W(DW4)) bus4 ();

    mips_bus_arbiter #(.N_PORTS(NP), .DATA_W(DW)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
    );

    mips_bus_arbiter #(.N_PORTS(NP4), .DATA_W(DW4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.master)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model (2-port instance) ----------
    // A transfer is either on the bus, or completing (done pulse), or absent.
    logic        m_on_bus;
    logic        m_completing;
    int          m_port;
    logic        m_is_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;
    int          m_last;
    int          m_win;

    function automatic int pick(input logic [NP-1:0] reqs, input int last);
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NP; k++) begin
            if (reqs[(last + k) % NP]) return (last + k) % NP;
        end
`else
        for (int k = 0; k < NP; k++) begin
            if (reqs[k]) return k;
        end
`endif
        return 0;
    endfunction

    always_comb m_win = pick(bus2.port_read | bus2.port_write, m_last);

    // Advance the model by one clock of transfer progress.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_on_bus     <= 1'b0;
            m_completing <= 1'b0;
            m_port       <= 0;
            m_is_write   <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_be         <= '0;
            m_rdata      <= '0;
            m_last       <= NP - 1;
        end else if (m_completing) begin
            m_completing <= 1'b0;
        end else if (m_on_bus) begin
            if (!bus2.waitrequest) begin
                if (!m_is_write) m_rdata <= bus2.readdata;
                m_on_bus     <= 1'b0;
                m_completing <= 1'b1;
                m_last       <= m_port;
            end
        end else if ((bus2.port_read | bus2.port_write) != '0) begin
            m_on_bus   <= 1'b1;
            m_port     <= m_win;
            m_is_write <= bus2.port_write[m_win];
            m_addr     <= bus2.port_address[32*m_win +: 32];
            m_wdata    <= bus2.port_writedata[32*m_win +: 32];
            m_be       <= bus2.port_byteenable[4*m_win +: 4];
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("busy",          64'(bus2.busy),          64'(m_on_bus | m_completing));
        check("read",          64'(bus2.read),          64'(m_on_bus & ~m_is_write));
        check("write",         64'(bus2.write),         64'(m_on_bus & m_is_write));
        check("port_done",     64'(bus2.port_done),     m_completing ? 64'(1 << m_port) : 64'(0));
        check("port_readdata", 64'(bus2.port_readdata), 64'(m_rdata));
        if (m_on_bus) begin
            check("address",    64'(bus2.address),    64'(m_addr));
            check("writedata",  64'(bus2.writedata),  64'(m_wdata));
            check("byteenable", 64'(bus2.byteenable), 64'(m_be));
        end
        if (bus2.port_done != '0) begin
            $display("[TB] txn: port_done=%b port_readdata=0x%08h", bus2.port_done, bus2.port_readdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req2(input int p, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus2.port_read[p]              = rd;
        bus2.port_write[p]             = wr;
        bus2.port_address[32*p +: 32]  = a;
        bus2.port_writedata[32*p +: 32] = d;
        bus2.port_byteenable[4*p +: 4] = be;
    endtask

    task automatic clear_req2(input int p);
        bus2.port_read[p]  = 1'b0;
        bus2.port_write[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_cycles, stable_cycles, done_cycles;
        int rem [2];
        bit hold [2];
        int order_q[$];
        int exp_order [4];
        int done4 [4];
        int order4[$];
        logic be_seen;

        bus2.port_read = '0;  bus2.port_write = '0;
        bus2.port_address = '0; bus2.port_writedata = '0; bus2.port_byteenable = '0;
        bus2.waitrequest = 1'b0; bus2.readdata = '0;
        bus4.port_read = '0;  bus4.port_write = '0;
        bus4.port_address = '0; bus4.port_writedata = '0; bus4.port_byteenable = '0;
        bus4.waitrequest = 1'b0; bus4.readdata = '0;

        // Reset state
        #2;
        check("rst_read",       64'(bus2.read),          64'd0);
        check("rst_write",      64'(bus2.write),         64'd0);
        check("rst_busy",       64'(bus2.busy),          64'd0);
        check("rst_port_done",  64'(bus2.port_done),     64'd0);
        check("rst_address",    64'(bus2.address),       64'd0);
        check("rst_writedata",  64'(bus2.writedata),     64'd0);
        check("rst_byteenable", 64'(bus2.byteenable),    64'd0);
        check("rst_readdata",   64'(bus2.port_readdata), 64'd0);
        check("rst4_busy",      64'(bus4.busy),          64'd0);
        check("rst4_byteen",    64'(bus4.byteenable),    64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single read: request launched after edge E0, done after E2.
        bus2.waitrequest = 1'b0;
        bus2.readdata    = 32'h8C02_0004;
        set_req2(0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF);
        tick();
        check("t1_read_on_bus", 64'(bus2.read),    64'd1);
        check("t1_address",     64'(bus2.address), 64'hBFC0_0000);
        tick();
        check("t1_done",        64'(bus2.port_done),     64'b01);
        check("t1_read_dropped",64'(bus2.read),          64'd0);
        check("t1_readdata",    64'(bus2.port_readdata), 64'h8C02_0004);
        clear_req2(0);
        tick();
        check("t1_done_once",   64'(bus2.port_done), 64'd0);
        check("t1_idle",        64'(bus2.busy),      64'd0);

        // Write with four wait states.
        bus2.readdata    = 32'h1111_1111;
        bus2.waitrequest = 1'b1;
        set_req2(1, 1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
        wr_cycles = 0; stable_cycles = 0; done_cycles = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus2.write) wr_cycles++;
            if (bus2.write && bus2.address == 32'h0000_1000 &&
                bus2.writedata == 32'hDEAD_BEEF && bus2.byteenable == 4'b0011) stable_cycles++;
            if (bus2.port_done == 2'b10) begin
                done_cycles++;
                clear_req2(1);
            end
            if (c == 5) bus2.waitrequest = 1'b0;
        end
        check("t2_write_cycles",  64'(wr_cycles),          64'd5);
        check("t2_stable_cycles", 64'(stable_cycles),      64'd5);
        check("t2_done_pulses",   64'(done_cycles),        64'd1);
        check("t2_readdata_held", 64'(bus2.port_readdata), 64'h8C02_0004);

        // Contention: both ports want two transfers, re-requesting after done.
        bus2.readdata = 32'h0BAD_F00D;
        rem[0] = 2; rem[1] = 2; hold[0] = 1'b0; hold[1] = 1'b0;
        set_req2(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'hF);
        set_req2(1, 1'b0, 1'b1, 32'h0000_0200, 32'hA5A5_0001, 4'hC);
        for (int c = 0; c < 30 && (rem[0] > 0 || rem[1] > 0); c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (bus2.port_done[p]) begin
                    order_q.push_back(p);
                    rem[p]--;
                    clear_req2(p);
                    hold[p] = 1'b1;
                end else if (hold[p]) begin
                    hold[p] = 1'b0;
                    if (rem[p] > 0) begin
                        if (p == 0) set_req2(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'hF);
                        else        set_req2(1, 1'b0, 1'b1, 32'h0000_0200, 32'hA5A5_0001, 4'hC);
                    end
                end
            end
        end
        tick();
        tick();
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 1, 1};
`endif
        check("t3_grant_count", 64'(order_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < order_q.size()) check($sformatf("t3_grant_%0d", i), 64'(order_q[i]), 64'(exp_order[i]));
        end

        // Read and write together on one port: write wins.
        set_req2(0, 1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'hF);
        tick();
        check("t4_write", 64'(bus2.write), 64'd1);
        check("t4_read",  64'(bus2.read),  64'd0);
        tick();
        check("t4_done",  64'(bus2.port_done), 64'b01);
        clear_req2(0);
        tick();

        // Reset in the middle of a stalled read.
        bus2.waitrequest = 1'b1;
        set_req2(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        tick();
        tick();
        check("t5_busy_before", 64'(bus2.busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_read",    64'(bus2.read),      64'd0);
        check("t5_write",   64'(bus2.write),     64'd0);
        check("t5_busy",    64'(bus2.busy),      64'd0);
        check("t5_done",    64'(bus2.port_done), 64'd0);
        check("t5_address", 64'(bus2.address),   64'd0);
        clear_req2(1);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t5_no_done_after", 64'(bus2.port_done), 64'd0);
        bus2.waitrequest = 1'b0;
        bus2.readdata    = 32'h55AA_55AA;
        set_req2(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        tick();
        check("t5_regrant_read", 64'(bus2.read),    64'd1);
        check("t5_regrant_addr", 64'(bus2.address), 64'h0000_0400);
        tick();
        check("t5_regrant_done", 64'(bus2.port_done),     64'b01);
        check("t5_regrant_data", 64'(bus2.port_readdata), 64'h55AA_55AA);
        clear_req2(0);
        tick();

        // Four 64-bit ports all requesting at once.
        bus4.waitrequest = 1'b0;
        bus4.readdata    = 64'h0123_4567_89AB_CDEF;
        for (int p = 0; p < NP4; p++) begin
            done4[p] = 0;
            bus4.port_read[p]                 = (p % 2 == 0);
            bus4.port_write[p]                = (p % 2 == 1);
            bus4.port_address[32*p +: 32]     = 32'h0000_1000 * (p + 1);
            bus4.port_writedata[64*p +: 64]   = 64'hFEED_0000_0000_0000 + 64'(p);
            bus4.port_byteenable[8*p +: 8]    = 8'hA5;
        end
        be_seen = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if ((bus4.read | bus4.write) && !be_seen) begin
                be_seen = 1'b1;
                check("t6_byteenable", 64'(bus4.byteenable), 64'hA5);
            end
            for (int p = 0; p < NP4; p++) begin
                if (bus4.port_done[p]) begin
                    done4[p]++;
                    order4.push_back(p);
                    bus4.port_read[p]  = 1'b0;
                    bus4.port_write[p] = 1'b0;
                end
            end
        end
        for (int p = 0; p < NP4; p++) begin
            check($sformatf("t6_served_%0d", p), 64'(done4[p]), 64'd1);
        end
        check("t6_order_len", 64'(order4.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < order4.size()) check($sformatf("t6_order_%0d", i), 64'(order4[i]), 64'(i));
        end
        check("t6_readdata", bus4.port_readdata, 64'h0123_4567_89AB_CDEF);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
